// File: rtl/t04_muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package t04_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_signed_a(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/t04_muldiv_if.sv
// Request/response bundle between the datapath and the multiply/divide unit.
interface t04_muldiv_if
  import t04_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             kill;
  muldiv_op_t       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic             ack;
  logic             busy;

  modport master (
    output start, kill, op, src_a, src_b,
    input  result, ack, busy
  );

  modport slave (
    input  start, kill, op, src_a, src_b,
    output result, ack, busy
  );
endinterface

// File: rtl/t04_mul_step.sv
// One shift-add multiply iteration: adds the multiplicand times MUL_STEP multiplier bits.
module t04_mul_step #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic [2*WIDTH-1:0]  acc,
  input  logic [2*WIDTH-1:0]  mcand,
  input  logic [MUL_STEP-1:0] bits,
  output logic [2*WIDTH-1:0]  acc_next
);
  logic [2*WIDTH-1:0] pp;

  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (bits[j]) pp = pp + (mcand << j);
    end
    acc_next = acc + pp;
  end
endmodule

// File: rtl/t04_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// magnitude arithmetic with a single sign fix on the final iteration.
module t04_muldiv_unit
  import t04_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  t04_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_DIV = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_MUL = CW'(WIDTH / MUL_STEP);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t state, state_next;
  muldiv_op_t    op_in, op_q;
  logic [2:0]    op_bits;

  logic [2*WIDTH-1:0] acc, mcand, acc_next, prod;
  logic [WIDTH-1:0]   shreg, b_mag, rem_q, result_q;
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r, ack_q;

  logic               sa_neg, sb_neg, div_zero, div_ovf, fast;
  logic [WIDTH-1:0]   a_abs, b_abs, fast_result;
  logic [WIDTH:0]     rem_shift, diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_next, dvd_next, quot, remd, mul_res, div_res;

  logic load, fast_load, step, last, ack_next;

  assign op_in   = bus.op;
  assign op_bits = bus.op;

  // Operand capture: magnitudes only, signs remembered for the final fix.
  assign sa_neg   = is_signed_a(op_in) & bus.src_a[WIDTH-1];
  assign sb_neg   = is_signed_b(op_in) & bus.src_b[WIDTH-1];
  assign a_abs    = sa_neg ? -bus.src_a : bus.src_a;
  assign b_abs    = sb_neg ? -bus.src_b : bus.src_b;
  assign div_zero = (bus.src_b == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (bus.src_a == MIN_VAL) && (bus.src_b == '1);
  assign fast     = op_bits[2] & (div_zero | div_ovf);

  always_comb begin
    fast_result = '0;
    if (div_zero) fast_result = op_bits[1] ? bus.src_a : '1;
    else          fast_result = op_bits[1] ? '0 : MIN_VAL;
  end

  t04_mul_step #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul_step (
    .acc      (acc),
    .mcand    (mcand),
    .bits     (shreg[MUL_STEP-1:0]),
    .acc_next (acc_next)
  );

  assign prod    = neg_q ? -acc_next : acc_next;
  assign mul_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  // Restoring division: dividend shifts out of shreg while quotient bits shift in.
  assign rem_shift = {rem_q, shreg[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, b_mag};
  assign qbit      = ~diff[WIDTH];
  assign rem_next  = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign dvd_next  = {shreg[WIDTH-2:0], qbit};
  assign quot      = neg_q ? -dvd_next : dvd_next;
  assign remd      = neg_r ? -rem_next : rem_next;
  assign div_res   = op_q[1] ? remd : quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    fast_load  = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    ack_next   = 1'b0;
    if (bus.kill) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (fast) begin
              fast_load  = 1'b1;
              ack_next   = 1'b1;
              state_next = ST_DONE;
            end else begin
              load       = 1'b1;
              state_next = op_bits[2] ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          step = 1'b1;
          if (cnt == CW'(1)) begin
            last       = 1'b1;
            ack_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      shreg    <= '0;
      b_mag    <= '0;
      rem_q    <= '0;
      cnt      <= '0;
      result_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= ack_next;
      if (load) begin
        op_q  <= op_in;
        neg_q <= sa_neg ^ sb_neg;
        neg_r <= sa_neg;
        acc   <= '0;
        rem_q <= '0;
        mcand <= {{WIDTH{1'b0}}, a_abs};
        shreg <= op_bits[2] ? a_abs : b_abs;
        b_mag <= b_abs;
        cnt   <= op_bits[2] ? CNT_DIV : CNT_MUL;
      end
      if (fast_load) result_q <= fast_result;
      if (step) begin
        cnt <= cnt - 1'b1;
        if (state == ST_MUL) begin
          acc   <= acc_next;
          mcand <= mcand << MUL_STEP;
          shreg <= shreg >> MUL_STEP;
        end else begin
          rem_q <= rem_next;
          shreg <= dvd_next;
        end
        if (last) result_q <= (state == ST_MUL) ? mul_res : div_res;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = (state != ST_IDLE);
endmodule

// File: tb/tb_t04_muldiv_unit.sv
// Directed bench for t04_muldiv_unit: one MUL_STEP=1 instance and one MUL_STEP=4 instance.
module tb_t04_muldiv_unit;
  import t04_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   acks;
  int   cyc;

  always #5 clk = ~clk;

  t04_muldiv_if #(.WIDTH(32)) bus1 ();
  t04_muldiv_if #(.WIDTH(32)) bus4 ();

  t04_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  t04_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input bit s);
    return s ? bus4.ack : bus1.ack;
  endfunction

  function automatic logic busy_of(input bit s);
    return s ? bus4.busy : bus1.busy;
  endfunction

  function automatic logic [31:0] res_of(input bit s);
    return s ? bus4.result : bus1.result;
  endfunction

  task automatic drive(input bit s, input logic st, input muldiv_op_t o,
                       input logic [31:0] a, input logic [31:0] b);
    if (s) begin
      bus4.start = st; bus4.op = o; bus4.src_a = a; bus4.src_b = b;
    end else begin
      bus1.start = st; bus1.op = o; bus1.src_a = a; bus1.src_b = b;
    end
  endtask

  // Latency is counted in edges, the start-sampling edge being edge 1.
  task automatic run(input bit s, input muldiv_op_t o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                     input string tag);
    int lat;
    @(negedge clk);
    drive(s, 1'b1, o, a, b);
    @(posedge clk); #1;
    drive(s, 1'b0, o, a, b);
    lat = 1;
    while (!ack_of(s) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_res"}, res_of(s), exp);
    check({tag, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
    check({tag, "_ack_off"}, {31'b0, ack_of(s)}, 32'd0);
    check({tag, "_busy_off"}, {31'b0, busy_of(s)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus1.kill = 1'b0;
    bus4.kill = 1'b0;
    drive(1'b0, 1'b0, OP_MUL, '0, '0);
    drive(1'b1, 1'b0, OP_MUL, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus1.result, 32'd0);
    check("rst_ack", {31'b0, bus1.ack}, 32'd0);
    check("rst_busy", {31'b0, bus1.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run(1'b0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run(1'b0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run(1'b0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run(1'b1, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, "mul_s4");
    run(1'b1, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, "mulh_s4");
    run(1'b1, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, "mulhu_s4");
    run(1'b1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, "mulhsu_s4");

    run(1'b0, OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    run(1'b0, OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    run(1'b0, OP_DIVU, 32'd100,       32'd7, 32'd14,        33, "divu");
    run(1'b0, OP_REMU, 32'd100,       32'd7, 32'd2,         33, "remu");

    run(1'b0, OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_z");
    run(1'b0, OP_REM,  32'd5,         32'd0,         32'd5,         1, "rem_z");
    run(1'b0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(1'b0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Start held high across two back-to-back multiplies.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 32'd3, 32'd4);
    acks = 0;
    cyc = 0;
    while (acks < 1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (bus1.ack) acks++;
    end
    check("held1_res", bus1.result, 32'd12);
    drive(1'b0, 1'b1, OP_MUL, 32'd5, 32'd6);
    cyc = 0;
    while (acks < 2 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (bus1.ack) acks++;
    end
    check("held2_res", bus1.result, 32'd30);
    drive(1'b0, 1'b0, OP_MUL, 32'd5, 32'd6);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus1.ack) acks++;
    end
    check("held_acks", acks, 32'd2);

    // Kill during the tenth division iteration.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus1.kill = 1'b1;
    @(posedge clk); #1;
    check("kill_busy", {31'b0, bus1.busy}, 32'd0);
    check("kill_ack", {31'b0, bus1.ack}, 32'd0);
    check("kill_result", bus1.result, 32'd30);
    @(negedge clk);
    bus1.kill = 1'b0;
    acks = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus1.ack) acks++;
    end
    check("kill_no_ack", acks, 32'd0);
    run(1'b0, OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_after_kill");

    // Kill together with start in IDLE: nothing is captured.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 32'd2, 32'd2);
    bus1.kill = 1'b1;
    @(posedge clk); #1;
    check("kill_start_busy", {31'b0, bus1.busy}, 32'd0);
    drive(1'b0, 1'b0, OP_MUL, 32'd2, 32'd2);
    bus1.kill = 1'b0;

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 32'd3, 32'd4);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_MUL, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy_pre", {31'b0, bus1.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_result", bus1.result, 32'd0);
    check("arst_ack", {31'b0, bus1.ack}, 32'd0);
    check("arst_busy", {31'b0, bus1.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
